fetch_unit: RTL and testbench

Instruction fetch stage of the RV32I core, sitting directly upstream of the program memory and directly downstream of the branch/jump resolution logic. Owns the program counter, drives the memory's byte address every cycle, captures the word returned one cycle later, and hands (instruction, PC) pairs to decode through a valid/ready handshake. A 2-entry buffer absorbs decode back-pressure without losing the in-flight memory read. Redirects flush all buffered and in-flight instructions.

---
 rtl/fetch_unit.sv | 109 ++++++++++
 tb/tb_fetch_unit.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
`default_nettype none
// fetch_unit: RV32I fetch stage with PC, one-cycle memory read pipeline and 2-entry decode buffer.
// Optional feature macro MISALIGN_TRAP_EN: a misaligned redirect halts fetch and raises fetch_misaligned.
module fetch_unit #(
  parameter int                    ADDR_WIDTH = 10,
  parameter int                    DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_data,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  output logic [DATA_WIDTH-1:0] instr,
  output logic [ADDR_WIDTH-1:0] instr_pc,
  output logic                  fetch_misaligned
);

  typedef enum logic [0:0] {RUN = 1'b0, HALT = 1'b1} state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] pc_q;
  logic [ADDR_WIDTH-1:0] req_pc_q;
  logic                  req_valid_q;
  logic [1:0]            count;
  logic [DATA_WIDTH-1:0] data0, data1;
  logic [ADDR_WIDTH-1:0] pc0, pc1;
  logic                  pop, push, issue;
  logic [2:0]            occ;
  logic [ADDR_WIDTH-1:0] target;

  assign pop    = (count != 2'd0) & instr_ready;
  assign push   = req_valid_q & ~redirect_valid;
  // Slots committed next cycle: buffered + in-flight - leaving now.
  assign occ    = {1'b0, count} + {2'b00, req_valid_q} - {2'b00, pop};
  assign issue  = (state == RUN) & ~redirect_valid & (occ < 3'd2);
  assign target = redirect_pc & ~ADDR_WIDTH'(3);

  assign mem_addr    = pc_q;
  assign instr_valid = (count != 2'd0);
  assign instr       = data0;
  assign instr_pc    = pc0;

`ifdef MISALIGN_TRAP_EN
  logic misaligned_q;
  assign fetch_misaligned = misaligned_q;
`else
  assign fetch_misaligned = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= RUN;
      pc_q        <= RESET_PC;
      req_pc_q    <= '0;
      req_valid_q <= 1'b0;
      count       <= 2'd0;
      data0       <= '0;
      data1       <= '0;
      pc0         <= '0;
      pc1         <= '0;
`ifdef MISALIGN_TRAP_EN
      misaligned_q <= 1'b0;
`endif
    end else if (redirect_valid) begin
      count       <= 2'd0;
      req_valid_q <= 1'b0;
      pc_q        <= target;
`ifdef MISALIGN_TRAP_EN
      if (redirect_pc[1:0] != 2'b00) begin
        state        <= HALT;
        misaligned_q <= 1'b1;
      end else begin
        state        <= RUN;
        misaligned_q <= 1'b0;
      end
`endif
    end else begin
      req_valid_q <= issue;
      if (issue) begin
        req_pc_q <= pc_q;
        pc_q     <= pc_q + ADDR_WIDTH'(4);
      end
      if (pop) begin
        data0 <= data1;
        pc0   <= pc1;
      end
      // Incoming word lands in the head slot when the buffer is (or becomes) empty.
      if (push) begin
        if ((count == 2'd0) || ((count == 2'd1) && pop)) begin
          data0 <= mem_data;
          pc0   <= req_pc_q;
        end else begin
          data1 <= mem_data;
          pc1   <= req_pc_q;
        end
      end
      count <= count + {1'b0, push} - {1'b0, pop};
`ifndef SYNTHESIS
      assert (!(push && !pop && (count == 2'd2)));
`endif
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// tb_fetch_unit: directed stimulus with a queue-based scoreboard checking every decode handshake.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [9:0]  mem_addr;
  logic [31:0] mem_data;
  logic        redirect_valid;
  logic [9:0]  redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [9:0]  instr_pc;
  logic        fetch_misaligned;

  int n_cmp = 0;
  int n_err = 0;
  logic [9:0] exp_q[$];
  logic [9:0] mon_pc;

  fetch_unit #(.ADDR_WIDTH(10), .DATA_WIDTH(32), .RESET_PC(10'h000)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .mem_addr         (mem_addr),
    .mem_data         (mem_data),
    .redirect_valid   (redirect_valid),
    .redirect_pc      (redirect_pc),
    .instr_valid      (instr_valid),
    .instr_ready      (instr_ready),
    .instr            (instr),
    .instr_pc         (instr_pc),
    .fetch_misaligned (fetch_misaligned)
  );

  always #5 clk = ~clk;

  // Program memory: word i holds 0x1000 + i, registered read.
  always @(posedge clk) mem_data <= 32'h1000 + {24'b0, mem_addr[9:2]};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_seq(input logic [9:0] start, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(start + 10'(4 * i));
  endtask

  // Monitor: every accepted instruction must be the next scoreboard entry.
  always @(negedge clk) begin
    if (rst_n && instr_valid && instr_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_instr: got pc %h, required no output", instr_pc);
      end else begin
        mon_pc = exp_q.pop_front();
        chk("instr_pc", {22'b0, instr_pc}, {22'b0, mon_pc});
        chk("instr", instr, 32'h1000 + {24'b0, mon_pc[9:2]});
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    instr_ready = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    repeat (3) tick();
    chk("rst_valid", {31'b0, instr_valid}, 0);
    chk("rst_instr", instr, 0);
    chk("rst_instr_pc", {22'b0, instr_pc}, 0);
    chk("rst_mem_addr", {22'b0, mem_addr}, 0);
    chk("rst_misaligned", {31'b0, fetch_misaligned}, 0);

    // Stream from reset, then stall for 5 cycles from cycle 3.
    push_seq(10'h000, 6);
    rst_n = 1'b1;
    instr_ready = 1'b1;                         // cycle 0
    chk("c0_mem_addr", {22'b0, mem_addr}, 0);
    chk("c0_valid", {31'b0, instr_valid}, 0);
    tick();                                     // cycle 1
    chk("c1_valid", {31'b0, instr_valid}, 0);
    tick();                                     // cycle 2
    chk("c2_valid", {31'b0, instr_valid}, 1);
    chk("c2_pc", {22'b0, instr_pc}, 0);
    tick();                                     // cycle 3
    instr_ready = 1'b0;
    repeat (4) tick();                          // cycle 7
    chk("stall_mem_addr", {22'b0, mem_addr}, 32'h00C);
    chk("stall_head_pc", {22'b0, instr_pc}, 32'h004);
    chk("stall_valid", {31'b0, instr_valid}, 1);
    tick();                                     // cycle 8
    instr_ready = 1'b1;
    repeat (5) tick();                          // cycle 13
    instr_ready = 1'b0;
    tick();                                     // cycle 14: two buffered

    // Redirect with a full buffer.
    push_seq(10'h040, 3);
    redirect_valid = 1'b1;
    redirect_pc = 10'h040;
    tick();                                     // R+1
    redirect_valid = 1'b0;
    instr_ready = 1'b1;
    chk("r1_mem_addr", {22'b0, mem_addr}, 32'h040);
    chk("r1_valid", {31'b0, instr_valid}, 0);
    tick();                                     // R+2
    chk("r2_valid", {31'b0, instr_valid}, 0);
    tick();                                     // R+3
    chk("r3_valid", {31'b0, instr_valid}, 1);
    chk("r3_pc", {22'b0, instr_pc}, 32'h040);
    tick();                                     // R+4
    tick();                                     // R+5: 0x48 popped with redirect

    // Redirect coincident with a pop, towards the top of the address space.
    exp_q.push_back(10'h3F8);
    exp_q.push_back(10'h3FC);
    exp_q.push_back(10'h000);
    exp_q.push_back(10'h004);
    redirect_valid = 1'b1;
    redirect_pc = 10'h3F8;
    tick();                                     // R2+1
    redirect_valid = 1'b0;
    chk("pop_redir_r1_valid", {31'b0, instr_valid}, 0);
    tick();
    chk("pop_redir_r2_valid", {31'b0, instr_valid}, 0);
    tick();                                     // R2+3
    chk("pop_redir_r3_pc", {22'b0, instr_pc}, 32'h3F8);
    tick();
    tick();                                     // R2+5
    chk("wrap_pc", {22'b0, instr_pc}, 0);
    tick();
    tick();                                     // R2+7
    instr_ready = 1'b0;
    tick();                                     // R3

    // Misaligned redirect.
`ifndef MISALIGN_TRAP_EN
    push_seq(10'h040, 3);
`endif
    redirect_valid = 1'b1;
    redirect_pc = 10'h042;
    tick();                                     // R3+1
    redirect_valid = 1'b0;
    instr_ready = 1'b1;
`ifdef MISALIGN_TRAP_EN
    chk("mis_flag_set", {31'b0, fetch_misaligned}, 1);
    chk("mis_valid_r1", {31'b0, instr_valid}, 0);
`else
    chk("mis_flag_tied", {31'b0, fetch_misaligned}, 0);
    chk("mis_mem_addr", {22'b0, mem_addr}, 32'h040);
`endif
    tick();
    tick();                                     // R3+3
`ifdef MISALIGN_TRAP_EN
    chk("mis_halt_valid", {31'b0, instr_valid}, 0);
    chk("mis_flag_hold", {31'b0, fetch_misaligned}, 1);
`else
    chk("mis_masked_valid", {31'b0, instr_valid}, 1);
    chk("mis_masked_pc", {22'b0, instr_pc}, 32'h040);
`endif
    tick();
    tick();                                     // R3+5

    // Aligned redirect resumes fetch.
    push_seq(10'h080, 3);
    redirect_valid = 1'b1;
    redirect_pc = 10'h080;
    tick();
    redirect_valid = 1'b0;
    chk("align_flag_clr", {31'b0, fetch_misaligned}, 0);
    chk("align_r1_valid", {31'b0, instr_valid}, 0);
    tick();
    chk("align_r2_valid", {31'b0, instr_valid}, 0);
    tick();                                     // +3
    chk("align_r3_valid", {31'b0, instr_valid}, 1);
    chk("align_r3_pc", {22'b0, instr_pc}, 32'h080);
    tick();
    tick();
    tick();

    // Reset mid-stream drops everything buffered and in flight.
    rst_n = 1'b0;
    tick();
    chk("midrst_valid", {31'b0, instr_valid}, 0);
    chk("midrst_mem_addr", {22'b0, mem_addr}, 0);
    tick();
    push_seq(10'h000, 3);
    rst_n = 1'b1;                               // cycle 0
    tick();
    chk("rerst_c1_valid", {31'b0, instr_valid}, 0);
    tick();                                     // cycle 2
    chk("rerst_c2_pc", {22'b0, instr_pc}, 0);
    tick();
    tick();
    tick();                                     // cycle 5
    instr_ready = 1'b0;
    tick();
    tick();
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
